// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared encodings for the memory/writeback stage
package mem_wb_stage_pkg;

  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_MEM  = 3'b001;
  localparam logic [2:0] WB_PC4  = 3'b010;
  localparam logic [2:0] WB_IMMD = 3'b011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS      = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// rtl/mem_wb_stage_lsu_align.sv - store lane steering, load extraction, access legality
module mem_wb_stage_lsu_align
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       lane,
  input  logic [2:0]       funct3,
  input  logic             mem_re,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] wdata,
  output logic [3:0]       be,
  output logic             misaligned,
  output logic             illegal,
  input  logic [1:0]       ld_lane,
  input  logic [2:0]       ld_funct3,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    illegal = 1'b0;
    if (mem_re && mem_we) begin
      illegal = 1'b1;
    end else if (mem_re) begin
      illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end else if (mem_we) begin
      illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    end
    // Size is funct3[1:0]; only meaningful once the access is known legal.
    misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                 ((funct3[1:0] == 2'b10) && (lane != 2'b00));
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (mem_we) begin
      case (funct3)
        F3_B: begin
          be    = 4'b0001 << lane;
          wdata = {(WIDTH/8){store_data[7:0]}};
        end
        F3_H: begin
          be    = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {(WIDTH/16){store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = rdata[{ld_lane, 3'b000} +: 8];
    ld_half = rdata[{ld_lane[1], 4'b0000} +: 16];
    case (ld_funct3)
      F3_B:    ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
      F3_H:    ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I memory access and writeback stage with req/ack data bus
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_ex_valid,
  input  logic [WIDTH-1:0] i_ex_alu_result,
  input  logic [WIDTH-1:0] i_ex_store_data,
  input  logic [WIDTH-1:0] i_ex_pc_plus4,
  input  logic [WIDTH-1:0] i_ex_immd,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_rf_we,
  input  logic [2:0]       i_ex_wb_src,
  input  logic             i_ex_mem_re,
  input  logic             i_ex_mem_we,
  input  logic [2:0]       i_ex_funct3,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]       o_dmem_be,
  input  logic             i_dmem_ack,
  input  logic             i_dmem_err,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic             o_wb_we,
  output logic [4:0]       o_wb_rd,
  output logic [WIDTH-1:0] o_wb_data,
  output logic             o_stall,
  output logic             o_mem_exc,
  output logic [1:0]       o_mem_exc_cause
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [1:0]       lane_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic             rf_we_q;

  logic [WIDTH-1:0] st_wdata;
  logic [3:0]       st_be;
  logic             misaligned;
  logic             illegal;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] wb_mux;

  logic accept, is_mem, mem_ok, done_ack, abort;

  mem_wb_stage_lsu_align #(.WIDTH(WIDTH)) u_align (
    .lane       (i_ex_alu_result[1:0]),
    .funct3     (i_ex_funct3),
    .mem_re     (i_ex_mem_re),
    .mem_we     (i_ex_mem_we),
    .store_data (i_ex_store_data),
    .wdata      (st_wdata),
    .be         (st_be),
    .misaligned (misaligned),
    .illegal    (illegal),
    .ld_lane    (lane_q),
    .ld_funct3  (funct3_q),
    .rdata      (i_dmem_rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    accept   = (state == ST_IDLE) && i_ex_valid;
    is_mem   = i_ex_mem_re || i_ex_mem_we;
    mem_ok   = accept && is_mem && !illegal && !misaligned;
    done_ack = (state == ST_ACCESS) && i_dmem_ack && !i_dmem_err;
    // Ack on the last allowed cycle still completes; only silence times out.
    abort    = (state == ST_ACCESS) &&
               (i_dmem_err || (!i_dmem_ack && (cnt == CNT_LAST)));
  end

  always_comb begin
    case (i_ex_wb_src)
      WB_PC4:         wb_mux = i_ex_pc_plus4;
      WB_IMMD:        wb_mux = i_ex_immd;
      WB_ALU, WB_MEM: wb_mux = i_ex_alu_result;
      default:        wb_mux = i_ex_alu_result;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (mem_ok) state_next = ST_ACCESS;
      ST_ACCESS: if (done_ack || abort) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_stall    = (state == ST_ACCESS);
    o_dmem_req = (state == ST_ACCESS);
    o_dmem_we  = (state == ST_ACCESS) && we_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt             <= '0;
      we_q            <= 1'b0;
      lane_q          <= 2'b00;
      funct3_q        <= 3'b000;
      rd_q            <= 5'd0;
      rf_we_q         <= 1'b0;
      o_dmem_addr     <= '0;
      o_dmem_wdata    <= '0;
      o_dmem_be       <= 4'b0000;
      o_wb_we         <= 1'b0;
      o_wb_rd         <= 5'd0;
      o_wb_data       <= '0;
      o_mem_exc       <= 1'b0;
      o_mem_exc_cause <= 2'b00;
    end else begin
      o_wb_we   <= 1'b0;
      o_mem_exc <= 1'b0;
      if (accept) begin
        if (is_mem) begin
          if (illegal) begin
            o_mem_exc       <= 1'b1;
            o_mem_exc_cause <= CAUSE_ILLEGAL;
          end else if (misaligned) begin
            o_mem_exc       <= 1'b1;
            o_mem_exc_cause <= CAUSE_MISALIGN;
          end else begin
            cnt          <= '0;
            we_q         <= i_ex_mem_we;
            lane_q       <= i_ex_alu_result[1:0];
            funct3_q     <= i_ex_funct3;
            rd_q         <= i_ex_rd;
            rf_we_q      <= i_ex_rf_we;
            o_dmem_addr  <= {i_ex_alu_result[WIDTH-1:2], 2'b00};
            o_dmem_wdata <= st_wdata;
            o_dmem_be    <= st_be;
          end
        end else if (i_ex_rf_we && (i_ex_rd != 5'd0)) begin
          o_wb_we   <= 1'b1;
          o_wb_rd   <= i_ex_rd;
          o_wb_data <= wb_mux;
        end
      end else if (state == ST_ACCESS) begin
        if (done_ack) begin
          if (!we_q && rf_we_q && (rd_q != 5'd0)) begin
            o_wb_we   <= 1'b1;
            o_wb_rd   <= rd_q;
            o_wb_data <= ld_data;
          end
        end else if (abort) begin
          o_mem_exc       <= 1'b1;
          o_mem_exc_cause <= CAUSE_BUS;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic [31:0] ex_alu, ex_sd, ex_pc4, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rf_we;
  logic [2:0]  ex_src;
  logic        ex_re, ex_we;
  logic [2:0]  ex_f3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack, dmem_err;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, mem_exc;
  logic [1:0]  mem_exc_cause;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t        exp_wb[$];
  logic [1:0] exp_exc[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_ex_valid      (ex_valid),
    .i_ex_alu_result (ex_alu),
    .i_ex_store_data (ex_sd),
    .i_ex_pc_plus4   (ex_pc4),
    .i_ex_immd       (ex_imm),
    .i_ex_rd         (ex_rd),
    .i_ex_rf_we      (ex_rf_we),
    .i_ex_wb_src     (ex_src),
    .i_ex_mem_re     (ex_re),
    .i_ex_mem_we     (ex_we),
    .i_ex_funct3     (ex_f3),
    .o_dmem_req      (dmem_req),
    .o_dmem_we       (dmem_we),
    .o_dmem_addr     (dmem_addr),
    .o_dmem_wdata    (dmem_wdata),
    .o_dmem_be       (dmem_be),
    .i_dmem_ack      (dmem_ack),
    .i_dmem_err      (dmem_err),
    .i_dmem_rdata    (dmem_rdata),
    .o_wb_we         (wb_we),
    .o_wb_rd         (wb_rd),
    .o_wb_data       (wb_data),
    .o_stall         (stall),
    .o_mem_exc       (mem_exc),
    .o_mem_exc_cause (mem_exc_cause)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rfwe, input logic [2:0] src,
                       input logic [31:0] pc4, input logic [31:0] imm);
    ex_valid = 1'b1;
    ex_re    = re;
    ex_we    = we;
    ex_f3    = f3;
    ex_alu   = alu;
    ex_sd    = sd;
    ex_rd    = rd;
    ex_rf_we = rfwe;
    ex_src   = src;
    ex_pc4   = pc4;
    ex_imm   = imm;
  endtask

  // Answers the outstanding request after `waits` silent cycles; returns request length.
  task automatic run_bus(input int waits, input logic [31:0] rdata, input logic err,
                         output int n);
    n = 0;
    while (dmem_req && n < 40) begin
      if (n == waits) begin
        if (err) dmem_err = 1'b1;
        else begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end
      tick();
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (wb_we === 1'b1) begin
        if (exp_wb.size() == 0) check("wb_unexpected", {27'd0, wb_rd}, 32'hFFFF_FFFF);
        else begin
          wb_t e;
          e = exp_wb.pop_front();
          check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          check("wb_data", wb_data, e.data);
        end
      end
      if (mem_exc === 1'b1) begin
        if (exp_exc.size() == 0) check("exc_unexpected", {30'd0, mem_exc_cause}, 32'hFFFF_FFFF);
        else begin
          logic [1:0] c;
          c = exp_exc.pop_front();
          check("exc_cause", {30'd0, mem_exc_cause}, {30'd0, c});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; ex_valid = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    drive(0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0);
    ex_valid = 1'b0;
    tick(); tick();
    check("rst_req",   {31'd0, dmem_req}, 0);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_addr",  dmem_addr, 0);
    check("rst_be",    {28'd0, dmem_be}, 0);
    check("rst_wbwe",  {31'd0, wb_we}, 0);
    check("rst_exc",   {31'd0, mem_exc}, 0);
    rstn = 1'b1;
    tick();

    // ALU writeback
    exp_wb.push_back('{5'd5, 32'h0000_1234});
    drive(0, 0, 3'b000, 32'h1234, 0, 5'd5, 1, 3'b000, 0, 0);
    tick(); ex_valid = 1'b0;
    check("alu_stall", {31'd0, stall}, 0);
    tick();

    // LB with 3 wait states; next ALU op held behind it
    exp_wb.push_back('{5'd7, 32'hFFFF_FF80});
    exp_wb.push_back('{5'd9, 32'h0000_0055});
    drive(1, 0, 3'b000, 32'h103, 0, 5'd7, 1, 3'b001, 0, 0);
    tick();
    check("lb_req",  {31'd0, dmem_req}, 1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_be",   {28'd0, dmem_be}, 32'hF);
    check("lb_we",   {31'd0, dmem_we}, 0);
    drive(0, 0, 3'b000, 32'h55, 0, 5'd9, 1, 3'b000, 0, 0);
    run_bus(3, 32'h80FF_FFFF, 0, cyc);
    check("lb_stall_len", cyc, 4);
    tick(); ex_valid = 1'b0;
    tick();

    // LBU same lane
    exp_wb.push_back('{5'd8, 32'h0000_0080});
    drive(1, 0, 3'b100, 32'h103, 0, 5'd8, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    run_bus(0, 32'h80FF_FFFF, 0, cyc);
    check("lbu_len", cyc, 1);
    tick();

    // LH upper half, sign-extended
    exp_wb.push_back('{5'd12, 32'hFFFF_8001});
    drive(1, 0, 3'b001, 32'h102, 0, 5'd12, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    run_bus(1, 32'h8001_0000, 0, cyc);
    check("lh_len", cyc, 2);
    tick();

    // SH to upper half: no writeback
    drive(0, 1, 3'b001, 32'h202, 32'hABCD_1234, 5'd6, 0, 3'b000, 0, 0);
    tick(); ex_valid = 1'b0;
    check("sh_addr",  dmem_addr, 32'h200);
    check("sh_be",    {28'd0, dmem_be}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    check("sh_we",    {31'd0, dmem_we}, 1);
    run_bus(0, 0, 0, cyc);
    tick();

    // SB lane 1
    drive(0, 1, 3'b000, 32'h205, 32'h0000_00A5, 5'd0, 0, 3'b000, 0, 0);
    tick(); ex_valid = 1'b0;
    check("sb_be",    {28'd0, dmem_be}, 32'h2);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    run_bus(0, 0, 0, cyc);
    tick();

    // Misaligned LW, next instruction accepted the following cycle
    exp_exc.push_back(2'b01);
    exp_wb.push_back('{5'd3, 32'hDEAD_0000});
    drive(1, 0, 3'b010, 32'h101, 0, 5'd3, 1, 3'b001, 0, 0);
    tick();
    check("mis_req", {31'd0, dmem_req}, 0);
    drive(0, 0, 3'b000, 0, 0, 5'd3, 1, 3'b011, 0, 32'hDEAD_0000);
    tick(); ex_valid = 1'b0;
    check("mis_next_wb", {31'd0, wb_we}, 1);
    tick();

    // Illegal encodings
    exp_exc.push_back(2'b11);
    drive(1, 0, 3'b011, 32'h0, 0, 5'd4, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    check("ill_ld_req", {31'd0, dmem_req}, 0);
    tick();
    exp_exc.push_back(2'b11);
    drive(0, 1, 3'b100, 32'h0, 0, 5'd0, 0, 3'b000, 0, 0);
    tick(); ex_valid = 1'b0;
    tick();
    exp_exc.push_back(2'b11);
    drive(1, 1, 3'b010, 32'h0, 0, 5'd4, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    check("ill_both_req", {31'd0, dmem_req}, 0);
    tick();

    // Bus error
    exp_exc.push_back(2'b10);
    drive(1, 0, 3'b010, 32'h300, 0, 5'd10, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    run_bus(2, 0, 1, cyc);
    check("err_len", cyc, 3);
    tick();

    // Timeout
    exp_exc.push_back(2'b10);
    drive(1, 0, 3'b010, 32'h300, 0, 5'd10, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    run_bus(100, 0, 0, cyc);
    check("to_len", cyc, 16);
    check("to_stall", {31'd0, stall}, 0);
    tick();

    // Ack on the last timeout cycle wins
    exp_wb.push_back('{5'd11, 32'hCAFE_F00D});
    drive(1, 0, 3'b010, 32'h300, 0, 5'd11, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    run_bus(15, 32'hCAFE_F00D, 0, cyc);
    check("ack16_len", cyc, 16);
    tick();

    // PC+4 and out-of-range wb_src
    exp_wb.push_back('{5'd1, 32'h0000_1004});
    drive(0, 0, 3'b000, 32'h99, 0, 5'd1, 1, 3'b010, 32'h1004, 0);
    tick(); ex_valid = 1'b0;
    tick();
    exp_wb.push_back('{5'd2, 32'h0000_0077});
    drive(0, 0, 3'b000, 32'h77, 0, 5'd2, 1, 3'b110, 32'h1004, 32'h5);
    tick(); ex_valid = 1'b0;
    tick();

    // Reset during access, then a stale ack
    drive(1, 0, 3'b010, 32'h400, 0, 5'd4, 1, 3'b001, 0, 0);
    tick(); ex_valid = 1'b0;
    tick(); tick();
    rstn = 1'b0;
    tick();
    check("rstacc_req",   {31'd0, dmem_req}, 0);
    check("rstacc_stall", {31'd0, stall}, 0);
    check("rstacc_addr",  dmem_addr, 0);
    check("rstacc_wdata", dmem_wdata, 0);
    check("rstacc_wbrd",  {27'd0, wb_rd}, 0);
    rstn = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    tick(); tick();
    dmem_ack = 1'b0;
    check("late_ack_req",  {31'd0, dmem_req}, 0);
    check("late_ack_wbwe", {31'd0, wb_we}, 0);

    // Write to x0 is suppressed
    drive(0, 0, 3'b000, 32'h4242, 0, 5'd0, 1, 3'b000, 0, 0);
    tick(); ex_valid = 1'b0;
    check("rd0_wbwe", {31'd0, wb_we}, 0);
    tick(); tick();

    check("wb_queue_drained",  exp_wb.size(), 0);
    check("exc_queue_drained", exp_exc.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
